// File: rtl/project_switch_ctrl_pkg.sv
// Shared types and constants for the project switch sequencer.
package project_switch_pkg;

    localparam int unsigned PROJ_ID_W   = 8;
    localparam int unsigned BUSY_BIT    = 16;
    localparam int unsigned BAD_ID_BIT  = 17;
    localparam int unsigned OVERRUN_BIT = 18;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        RESET,
        RELEASE
    } state_t;

endpackage

// File: rtl/project_switch_ctrl_if.sv
// Wishbone slave bus bundle for the project switch control register.
interface project_switch_ctrl_if;

    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/project_switch_ctrl_cycle_timer.sv
// Loadable 8-bit down-counter; done is high while the count sits at zero.
module cycle_timer #(
    parameter logic [7:0] RESET_VAL = '0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/project_switch_ctrl.sv
// Project switch sequencer: isolates pads, changes the mux select, then holds
// the newly selected project in reset before releasing it.
module project_switch_ctrl
    import project_switch_pkg::*;
#(
    parameter logic [31:0] ADDRESS_CTRL = 32'h3000_0000,
    parameter int unsigned NUM_PROJECTS = 5,
    parameter int unsigned GUARD_CYCLES = 4,
    parameter int unsigned RESET_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    project_switch_ctrl_if.slave wb,
    output logic [PROJ_ID_W-1:0] active_project,
    output logic                 io_isolate,
    output logic                 project_reset,
    output logic                 busy
);

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);
    localparam logic [7:0] RESET_LOAD = 8'(RESET_CYCLES - 1);

    state_t               state;
    logic [PROJ_ID_W-1:0] pending_id;
    logic                 bad_id;
    logic                 overrun;
    logic                 ack_q;
    logic [31:0]          status;

    logic                 valid, addr_hit, wr_req, rd_req, accept;
    logic                 wr_lane, id_ok, start, bad_set, overrun_set, rd_clr;
    logic [PROJ_ID_W-1:0] wr_id;
    logic                 tmr_load, tmr_done;
    logic [7:0]           tmr_val;
    logic                 unused_dat;

    assign valid    = wb.wbs_cyc_i & wb.wbs_stb_i;
    assign addr_hit = (wb.wbs_adr_i == ADDRESS_CTRL);
    assign wr_req   = valid & wb.wbs_we_i & (wb.wbs_sel_i != '0) & addr_hit;
    assign rd_req   = valid & ~wb.wbs_we_i & addr_hit;
    // Blocking acceptance in the cycle after an ack keeps a held request from double-acking.
    assign accept   = (wr_req | rd_req) & ~ack_q;

    assign wr_id       = wb.wbs_dat_i[PROJ_ID_W-1:0];
    assign unused_dat  = ^wb.wbs_dat_i[31:PROJ_ID_W];
    assign id_ok       = 32'(wr_id) < NUM_PROJECTS;
    assign wr_lane     = accept & wr_req & wb.wbs_sel_i[0];
    assign start       = wr_lane & id_ok & (state == IDLE);
    assign bad_set     = wr_lane & ~id_ok;
    assign overrun_set = wr_lane & id_ok & (state != IDLE);
    assign rd_clr      = accept & rd_req;

    always_comb begin
        status                   = '0;
        status[7:0]              = active_project;
        status[15:8]             = pending_id;
        status[BUSY_BIT]         = busy;
        status[BAD_ID_BIT]       = bad_id;
        status[OVERRUN_BIT]      = overrun;
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (start) begin
            tmr_load = 1'b1;
            tmr_val  = GUARD_LOAD;
        end else if (state == GUARD && tmr_done) begin
            tmr_load = 1'b1;
            tmr_val  = RESET_LOAD;
        end
    end

    cycle_timer #(
        .RESET_VAL(RESET_LOAD)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q      <= 1'b0;
            wb.wbs_dat_o <= '0;
            bad_id     <= 1'b0;
            overrun    <= 1'b0;
            pending_id <= '0;
        end else begin
            ack_q        <= accept;
            wb.wbs_dat_o <= rd_clr ? status : '0;
            if (bad_set)          bad_id <= 1'b1;
            else if (rd_clr)      bad_id <= 1'b0;
            if (overrun_set)      overrun <= 1'b1;
            else if (rd_clr)      overrun <= 1'b0;
            if (start)            pending_id <= wr_id;
        end
    end

    assign wb.wbs_ack_o = ack_q;

    // Select changes on the GUARD->RESET edge, so isolation brackets it on both sides.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= RESET;
            active_project <= '0;
            io_isolate     <= 1'b1;
            project_reset  <= 1'b1;
            busy           <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state      <= GUARD;
                    io_isolate <= 1'b1;
                    busy       <= 1'b1;
                end
                GUARD: if (tmr_done) begin
                    state          <= RESET;
                    active_project <= pending_id;
                    project_reset  <= 1'b1;
                end
                RESET: if (tmr_done) begin
                    state         <= RELEASE;
                    project_reset <= 1'b0;
                end
                RELEASE: begin
                    state      <= IDLE;
                    io_isolate <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state         <= RESET;
                    io_isolate    <= 1'b1;
                    project_reset <= 1'b1;
                    busy          <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_project_switch_ctrl.sv
// Directed self-checking bench for project_switch_ctrl.
module tb_project_switch_ctrl;

    localparam logic [31:0] ADDR = 32'h3000_0000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] active_project;
    logic       io_isolate;
    logic       project_reset;
    logic       busy;

    int assertions = 0;
    int failures   = 0;

    project_switch_ctrl_if wb ();

    project_switch_ctrl #(
        .ADDRESS_CTRL (ADDR),
        .NUM_PROJECTS (5),
        .GUARD_CYCLES (4),
        .RESET_CYCLES (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wb             (wb.slave),
        .active_project (active_project),
        .io_isolate     (io_isolate),
        .project_reset  (project_reset),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        wb.wbs_cyc_i = 1'b1;
        wb.wbs_stb_i = 1'b1;
        wb.wbs_we_i  = we;
        wb.wbs_sel_i = sel;
        wb.wbs_adr_i = adr;
        wb.wbs_dat_i = dat;
    endtask

    task automatic bus_idle();
        wb.wbs_cyc_i = 1'b0;
        wb.wbs_stb_i = 1'b0;
        wb.wbs_we_i  = 1'b0;
        wb.wbs_sel_i = '0;
        wb.wbs_adr_i = '0;
        wb.wbs_dat_i = '0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_v;
        bus_idle();
        #2 reset_n = 1'b0;
        #1;
        assertions++;
        if ({active_project, io_isolate, project_reset, busy, wb.wbs_ack_o} !== {8'd0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs: got act=%0d iso=%b rst=%b busy=%b ack=%b, want 0 1 1 1 0",
                     active_project, io_isolate, project_reset, busy, wb.wbs_ack_o);
        end
        assertions++;
        if (wb.wbs_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_dat: got %h want 00000000", wb.wbs_dat_o);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_v = (i <= 7) ? 3'b111 : (i == 8) ? 3'b101 : 3'b000;
            assertions++;
            if ({io_isolate, project_reset, busy} !== exp_v) begin
                failures++;
                $display("FAIL boot_seq[%0d]: got iso/rst/busy=%b want %b", i,
                         {io_isolate, project_reset, busy}, exp_v);
            end
        end
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        tick();
        assertions++;
        if ({wb.wbs_ack_o, wb.wbs_dat_o} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL boot_status: got ack=%b dat=%h want 1 00000000", wb.wbs_ack_o, wb.wbs_dat_o);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_switch();
        logic [10:0] exp_v;
        drive_req(1'b1, 4'hF, ADDR, 32'h2);
        tick();
        bus_idle();
        for (int i = 0; i <= 13; i++) begin
            if (i != 0) tick();
            if (i < 4)       exp_v = {8'd0, 3'b101};
            else if (i < 12) exp_v = {8'd2, 3'b111};
            else if (i == 12) exp_v = {8'd2, 3'b101};
            else             exp_v = {8'd2, 3'b000};
            assertions++;
            if ({active_project, io_isolate, project_reset, busy} !== exp_v) begin
                failures++;
                $display("FAIL switch_seq[%0d]: got act=%0d iso/rst/busy=%b want act=%0d %b", i,
                         active_project, {io_isolate, project_reset, busy}, exp_v[10:3], exp_v[2:0]);
            end
            if (i < 2) begin
                assertions++;
                if (wb.wbs_ack_o !== (i == 0)) begin
                    failures++;
                    $display("FAIL switch_ack[%0d]: got %b want %b", i, wb.wbs_ack_o, (i == 0));
                end
            end
        end
    endtask

    task automatic test_bad_id();
        drive_req(1'b1, 4'hF, ADDR, 32'h7);
        tick();
        bus_idle();
        assertions++;
        if ({wb.wbs_ack_o, busy, active_project} !== {1'b1, 1'b0, 8'd2}) begin
            failures++;
            $display("FAIL bad_id_write: got ack=%b busy=%b act=%0d want 1 0 2", wb.wbs_ack_o, busy, active_project);
        end
        tick();
        assertions++;
        if ({busy, wb.wbs_dat_o} !== {1'b0, 32'h0}) begin
            failures++;
            $display("FAIL bad_id_idle: got busy=%b dat=%h want 0 00000000", busy, wb.wbs_dat_o);
        end
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        tick();
        bus_idle();
        assertions++;
        if (wb.wbs_dat_o !== 32'h0002_0202) begin
            failures++;
            $display("FAIL bad_id_read1: got %h want 00020202", wb.wbs_dat_o);
        end
        tick();
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        tick();
        bus_idle();
        assertions++;
        if (wb.wbs_dat_o !== 32'h0000_0202) begin
            failures++;
            $display("FAIL bad_id_read2: got %h want 00000202", wb.wbs_dat_o);
        end
        tick();
    endtask

    task automatic test_overrun();
        bit done_seen = 0;
        drive_req(1'b1, 4'hF, ADDR, 32'h1);
        tick();
        bus_idle();
        tick();
        drive_req(1'b1, 4'hF, ADDR, 32'h3);
        tick();
        bus_idle();
        assertions++;
        if ({wb.wbs_ack_o, busy} !== 2'b11) begin
            failures++;
            $display("FAIL overrun_ack: got ack=%b busy=%b want 1 1", wb.wbs_ack_o, busy);
        end
        for (int i = 0; i < 40 && !done_seen; i++) begin
            tick();
            if (busy === 1'b0) done_seen = 1;
        end
        assertions++;
        if (!done_seen || active_project !== 8'd1) begin
            failures++;
            $display("FAIL overrun_final: got done=%0d act=%0d want 1 1", done_seen, active_project);
        end
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        tick();
        bus_idle();
        assertions++;
        if (wb.wbs_dat_o !== 32'h0004_0101) begin
            failures++;
            $display("FAIL overrun_read: got %h want 00040101", wb.wbs_dat_o);
        end
        tick();
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        tick();
        bus_idle();
        assertions++;
        if (wb.wbs_dat_o !== 32'h0000_0101) begin
            failures++;
            $display("FAIL overrun_clear: got %h want 00000101", wb.wbs_dat_o);
        end
        tick();
    endtask

    task automatic test_bus_edges();
        logic [4:0] acks;
        int         nacks;
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            acks[i] = wb.wbs_ack_o;
        end
        bus_idle();
        assertions++;
        if (acks !== 5'b10101) begin
            failures++;
            $display("FAIL held_strobe: got ack pattern %b want 10101", acks);
        end
        tick();
        drive_req(1'b1, 4'b0010, ADDR, 32'h3);
        tick();
        bus_idle();
        assertions++;
        if (wb.wbs_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL lane_ack: got %b want 1", wb.wbs_ack_o);
        end
        tick();
        assertions++;
        if ({busy, active_project} !== {1'b0, 8'd1}) begin
            failures++;
            $display("FAIL lane_ignore: got busy=%b act=%0d want 0 1", busy, active_project);
        end
        nacks = 0;
        drive_req(1'b1, 4'hF, ADDR + 32'h4, 32'h2);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wb.wbs_ack_o === 1'b1) nacks++;
        end
        bus_idle();
        assertions++;
        if (nacks != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL other_addr: got acks=%0d busy=%b want 0 0", nacks, busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_sequence();
        logic [2:0] exp_v;
        drive_req(1'b1, 4'hF, ADDR, 32'h4);
        tick();
        bus_idle();
        for (int i = 0; i < 5; i++) tick();
        assertions++;
        if ({active_project, io_isolate, project_reset} !== {8'd4, 2'b11}) begin
            failures++;
            $display("FAIL mid_reset_state: got act=%0d iso=%b rst=%b want 4 1 1",
                     active_project, io_isolate, project_reset);
        end
        tick();
        #2 reset_n = 1'b0;
        #1;
        assertions++;
        if ({active_project, io_isolate, project_reset, busy} !== {8'd0, 3'b111}) begin
            failures++;
            $display("FAIL mid_reset_async: got act=%0d iso/rst/busy=%b want 0 111",
                     active_project, {io_isolate, project_reset, busy});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_v = (i <= 7) ? 3'b111 : (i == 8) ? 3'b101 : 3'b000;
            assertions++;
            if ({active_project, io_isolate, project_reset, busy} !== {8'd0, exp_v}) begin
                failures++;
                $display("FAIL mid_reboot[%0d]: got act=%0d iso/rst/busy=%b want 0 %b", i,
                         active_project, {io_isolate, project_reset, busy}, exp_v);
            end
        end
        drive_req(1'b0, 4'hF, ADDR, 32'h0);
        tick();
        bus_idle();
        assertions++;
        if (wb.wbs_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL mid_reboot_status: got %h want 00000000", wb.wbs_dat_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_switch();
        test_bad_id();
        test_overrun();
        test_bus_edges();
        test_reset_mid_sequence();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
